// File: rtl/rr_mux_if.sv
// Handshake bundle for rr_mux_reg: K valid/ready input channels and one registered output.
// The lock signal exists only when RR_MUX_LOCK_EN is defined.
interface rr_mux_if #(
    parameter int unsigned N = 32,
    parameter int unsigned K = 4
);
    localparam int unsigned SELW = $clog2(K);

    logic [K-1:0]   in_valid;
    logic [K*N-1:0] in_data;
    logic [K-1:0]   in_ready;
    logic           out_valid;
    logic [N-1:0]   out_data;
    logic [SELW-1:0] out_sel;
    logic           out_ready;
`ifdef RR_MUX_LOCK_EN
    logic           lock;

    modport slave (
        input  in_valid, in_data, out_ready, lock,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, in_data, out_ready, lock,
        input  in_ready, out_valid, out_data, out_sel
    );
`else
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
`endif
endinterface

// File: rtl/rr_mux_reg.sv
// K-input round-robin arbitrating mux with a full-throughput output register.
// Optional grant locking for atomic multi-beat sequences under RR_MUX_LOCK_EN.
module rr_mux_reg #(
    parameter int unsigned N = 32,
    parameter int unsigned K = 4
) (
    input  logic     clk,
    input  logic     rst,
    rr_mux_if.slave  bus
);
    localparam int unsigned SELW = $clog2(K);

    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_next;
    logic [SELW-1:0] grant_idx;
    logic [SELW-1:0] cand;
    logic            grant_found;
    logic            load_c;
    logic            xfer_c;

    logic            valid_q;
    logic [N-1:0]    data_q;
    logic [SELW-1:0] sel_q;

`ifdef RR_MUX_LOCK_EN
    logic            locked;
    logic [SELW-1:0] lock_ch;
`endif

    // First valid channel at or after ptr, wrapping explicitly at K-1
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned off = 0; off < K; off++) begin
            cand = (32'(ptr) + off >= K) ? SELW'(32'(ptr) + off - K) : SELW'(32'(ptr) + off);
            if (!grant_found && bus.in_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
`ifdef RR_MUX_LOCK_EN
        // A held lock pins the grant even when that channel is idle
        if (locked) begin
            grant_found = 1'b1;
            grant_idx   = lock_ch;
        end
`endif
    end

    assign load_c   = !valid_q || bus.out_ready;
    assign xfer_c   = grant_found && load_c && !rst && bus.in_valid[grant_idx];
    assign ptr_next = (grant_idx == SELW'(K - 1)) ? '0 : grant_idx + SELW'(1);

    assign bus.in_ready  = (grant_found && load_c && !rst) ? (K'(1) << grant_idx) : '0;
    assign bus.out_valid = valid_q;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;

    // Output register: refill on transfer, otherwise drain when downstream accepts
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
        end else if (xfer_c) begin
            valid_q <= 1'b1;
            data_q  <= bus.in_data[32'(grant_idx)*N +: N];
            sel_q   <= grant_idx;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // Arbitration state; pointer moves past the winner unless the grant is being locked
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
`ifdef RR_MUX_LOCK_EN
            locked  <= 1'b0;
            lock_ch <= '0;
`endif
        end else if (xfer_c) begin
`ifdef RR_MUX_LOCK_EN
            if (bus.lock) begin
                locked  <= 1'b1;
                lock_ch <= grant_idx;
            end else begin
                locked  <= 1'b0;
                ptr     <= ptr_next;
            end
`else
            ptr <= ptr_next;
`endif
        end
    end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Self-checking bench for rr_mux_reg: a K=4/N=32 instance and a K=3/N=8 instance
// against a modulo-arithmetic reference model; lock scenario when RR_MUX_LOCK_EN is defined.
module tb_rr_mux_reg;
`ifdef RR_MUX_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_mux_if #(.N(32), .K(4)) a ();
    rr_mux_if #(.N(8),  .K(3)) b ();

    rr_mux_reg #(.N(32), .K(4)) dut_a (.clk(clk), .rst(rst), .bus(a.slave));
    rr_mux_reg #(.N(8),  .K(3)) dut_b (.clk(clk), .rst(rst), .bus(b.slave));

    int checks = 0;
    int errors = 0;

    // Reference state, instance a
    bit          ma_valid;
    logic [31:0] ma_data;
    int          ma_sel, ma_ptr, ma_lock_ch;
    bit          ma_locked;
    // Reference state, instance b
    bit          mb_valid;
    logic [7:0]  mb_data;
    int          mb_sel, mb_ptr;

    function automatic int search(input logic [3:0] v, input int p, input int k);
        for (int off = 0; off < k; off++)
            if (v[(p + off) % k]) return (p + off) % k;
        return -1;
    endfunction

    function automatic logic [127:0] rand_data4();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        ma_valid = 0; ma_data = '0; ma_sel = 0; ma_ptr = 0; ma_locked = 0; ma_lock_ch = 0;
        mb_valid = 0; mb_data = '0; mb_sel = 0; mb_ptr = 0;
    endtask

    // One clock on instance a: drive, check in_ready, advance model, check output register
    task automatic cycle_a(input logic [3:0] v, input logic [127:0] d, input logic r, input logic lk);
        int g;
        bit load;
        logic [3:0] exp_rdy;
        a.in_valid  = v;
        a.in_data   = d;
        a.out_ready = r;
`ifdef RR_MUX_LOCK_EN
        a.lock = lk;
`endif
        #1;
        load = !ma_valid || r;
        g = ma_locked ? ma_lock_ch : search(v, ma_ptr, 4);
        exp_rdy = (g >= 0 && load) ? 4'(1 << g) : 4'b0;
        checks++;
        if (a.in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL a_in_ready got %b want %b at %0t", a.in_ready, exp_rdy, $time);
        end
        if (g >= 0 && load && v[g]) begin
            ma_valid = 1;
            ma_data  = d[g*32 +: 32];
            ma_sel   = g;
            if (LOCK_EN && lk) begin
                ma_locked  = 1;
                ma_lock_ch = g;
            end else begin
                ma_locked = 0;
                ma_ptr    = (g + 1) % 4;
            end
        end else if (ma_valid && r) begin
            ma_valid = 0;
        end
        @(posedge clk); #1;
        checks++;
        if ({a.out_valid, a.out_data, a.out_sel} !== {ma_valid, ma_data, 2'(ma_sel)}) begin
            errors++;
            $display("FAIL a_out got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                     a.out_valid, a.out_data, a.out_sel, ma_valid, ma_data, ma_sel);
        end
    endtask

    task automatic cycle_b(input logic [2:0] v, input logic [23:0] d, input logic r);
        int g;
        bit load;
        logic [2:0] exp_rdy;
        b.in_valid  = v;
        b.in_data   = d;
        b.out_ready = r;
        #1;
        load = !mb_valid || r;
        g = search({1'b0, v}, mb_ptr, 3);
        exp_rdy = (g >= 0 && load) ? 3'(1 << g) : 3'b0;
        checks++;
        if (b.in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL b_in_ready got %b want %b at %0t", b.in_ready, exp_rdy, $time);
        end
        if (g >= 0 && load) begin
            mb_valid = 1;
            mb_data  = d[g*8 +: 8];
            mb_sel   = g;
            mb_ptr   = (g + 1) % 3;
        end else if (mb_valid && r) begin
            mb_valid = 0;
        end
        @(posedge clk); #1;
        checks++;
        if ({b.out_valid, b.out_data, b.out_sel} !== {mb_valid, mb_data, 2'(mb_sel)}) begin
            errors++;
            $display("FAIL b_out got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                     b.out_valid, b.out_data, b.out_sel, mb_valid, mb_data, mb_sel);
        end
    endtask

    // Two reset cycles with requests asserted (in_ready must stay low), then 5 idle cycles
    task automatic test_reset();
        rst = 1'b1;
        a.in_valid = 4'hF; a.in_data = rand_data4(); a.out_ready = 1'b1;
        b.in_valid = 3'h7; b.in_data = 24'h123456; b.out_ready = 1'b1;
`ifdef RR_MUX_LOCK_EN
        a.lock = 1'b0;
`endif
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (a.in_ready !== 4'b0 || b.in_ready !== 3'b0) begin
                errors++;
                $display("FAIL reset_in_ready got a=%b b=%b want 0", a.in_ready, b.in_ready);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0;
        b.in_valid = 3'b0;
        model_reset();
        for (int i = 0; i < 5; i++) cycle_a(4'b0, rand_data4(), 1'b1, 1'b0);
        checks++;
        if ({a.out_valid, a.out_data, a.out_sel} !== 35'b0) begin
            errors++;
            $display("FAIL reset_idle got v=%b d=%h s=%0d want all 0", a.out_valid, a.out_data, a.out_sel);
        end
    endtask

    task automatic test_rotation();
        logic [127:0] d;
        for (int i = 0; i < 4; i++) d[i*32 +: 32] = 32'hA0 + 32'(i);
        for (int i = 0; i < 8; i++) begin
            cycle_a(4'hF, d, 1'b1, 1'b0);
            checks++;
            if (a.out_sel !== 2'(i % 4) || a.out_data !== 32'hA0 + 32'(i % 4)) begin
                errors++;
                $display("FAIL rotation got s=%0d d=%h want s=%0d d=%h",
                         a.out_sel, a.out_data, i % 4, 32'hA0 + 32'(i % 4));
            end
        end
    endtask

    task automatic test_stall();
        logic [127:0] d2;
        cycle_a(4'b0100, rand_data4(), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle_a(4'b0100, rand_data4(), 1'b0, 1'b0);
            checks++;
            if (a.out_valid !== 1'b1 || a.out_sel !== 2'd2) begin
                errors++;
                $display("FAIL stall_hold got v=%b s=%0d want v=1 s=2", a.out_valid, a.out_sel);
            end
        end
        d2 = rand_data4();
        cycle_a(4'b0100, d2, 1'b1, 1'b0);
        checks++;
        if (a.out_valid !== 1'b1 || a.out_data !== d2[95:64]) begin
            errors++;
            $display("FAIL stall_refill got v=%b d=%h want v=1 d=%h", a.out_valid, a.out_data, d2[95:64]);
        end
    endtask

    task automatic test_reset_mid();
        cycle_a(4'b1000, rand_data4(), 1'b1, 1'b0);
        a.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (a.in_ready !== 4'b0) begin
            errors++;
            $display("FAIL mid_reset_ready got %b want 0000", a.in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if ({a.out_valid, a.out_data, a.out_sel} !== 35'b0) begin
            errors++;
            $display("FAIL mid_reset_out got v=%b d=%h s=%0d want all 0", a.out_valid, a.out_data, a.out_sel);
        end
        cycle_a(4'b1001, rand_data4(), 1'b1, 1'b0);
        checks++;
        if (a.out_sel !== 2'd0) begin
            errors++;
            $display("FAIL mid_reset_restart got s=%0d want 0", a.out_sel);
        end
    endtask

    task automatic test_random_a();
        for (int i = 0; i < 300; i++)
            cycle_a(4'($urandom), rand_data4(), 1'(($urandom % 4) != 0), 1'(($urandom % 4) == 0));
    endtask

    task automatic test_k3();
        rst = 1'b1;
        b.in_valid = 3'b0; b.out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        cycle_b(3'b100, 24'h33_22_11, 1'b1);
        cycle_b(3'b110, 24'h66_55_44, 1'b1);
        checks++;
        if (b.out_sel !== 2'd1 || b.out_data !== 8'h55) begin
            errors++;
            $display("FAIL k3_wrap got s=%0d d=%h want s=1 d=55", b.out_sel, b.out_data);
        end
        cycle_b(3'b111, 24'h99_88_77, 1'b1);
        cycle_b(3'b111, 24'hCC_BB_AA, 1'b1);
        checks++;
        if (b.out_sel !== 2'd0 || b.out_data !== 8'hAA) begin
            errors++;
            $display("FAIL k3_rotate got s=%0d d=%h want s=0 d=AA", b.out_sel, b.out_data);
        end
        for (int i = 0; i < 150; i++)
            cycle_b(3'($urandom), 24'($urandom), 1'(($urandom % 4) != 0));
    endtask

`ifdef RR_MUX_LOCK_EN
    task automatic test_lock();
        rst = 1'b1;
        a.in_valid = 4'b0; a.out_ready = 1'b1; a.lock = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        cycle_a(4'b0001, rand_data4(), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle_a(4'b0011, rand_data4(), 1'b1, 1'b1);
            checks++;
            if (a.out_sel !== 2'd1) begin
                errors++;
                $display("FAIL lock_beat got s=%0d want 1", a.out_sel);
            end
        end
        cycle_a(4'b0001, rand_data4(), 1'b1, 1'b1);
        checks++;
        if (a.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lock_idle got v=%b want 0", a.out_valid);
        end
        cycle_a(4'b0011, rand_data4(), 1'b1, 1'b0);
        cycle_a(4'b0101, rand_data4(), 1'b1, 1'b0);
        checks++;
        if (a.out_sel !== 2'd2) begin
            errors++;
            $display("FAIL lock_release got s=%0d want 2", a.out_sel);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        model_reset();
        test_reset();
        test_rotation();
        test_stall();
        test_reset_mid();
        test_random_a();
        test_k3();
`ifdef RR_MUX_LOCK_EN
        test_lock();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
